// File: rtl/rs_port_arbiter.sv
// rs_port_arbiter: round-robin arbiter that hands one shared source-address
// port to one of NUM_CH controllers. The owner's address is passed through a
// register. Every change of owner goes through one IDLE cycle. A long-running
// owner is forced off after MAX_HOLD cycles when another channel is waiting.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module rs_port_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int MAX_HOLD   = 8,
  parameter int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] rs_in,
  output logic [NUM_CH-1:0]            gnt,
  output logic [SEL_W-1:0]             gnt_id,
  output logic                         rs_valid,
  output logic [ADDR_WIDTH-1:0]        rs_out
);

  // The hold counter must be able to reach MAX_HOLD, where it saturates.
  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_reg,    state_next;
  logic [NUM_CH-1:0]       gnt_reg,      gnt_next;
  logic [SEL_W-1:0]        gnt_id_reg,   gnt_id_next;
  logic                    valid_reg,    valid_next;
  logic [ADDR_WIDTH-1:0]   rs_out_reg,   rs_out_next;
  logic [CNT_W-1:0]        hold_reg,     hold_next;
  logic [SEL_W-1:0]        last_reg,     last_next;

  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_CH];
  logic [2*NUM_CH-1:0]     req_dbl;
  logic [NUM_CH-1:0]       req_rot;
  logic [SEL_W-1:0]        start_idx;
  logic [SEL_W-1:0]        pick_off;
  logic [SEL_W:0]          pick_sum;
  logic [SEL_W-1:0]        pick_id;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [ADDR_WIDTH-1:0]   own_addr;
  logic                    owner_req;
  logic                    others_req;
  logic                    rotate_due;

  // Unpack the per-channel address slices.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr
    assign addr_arr[gi] = rs_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Round-robin search starts one past the previous owner. The request
  // vector is rotated so that bit 0 is the starting channel; a fixed-priority
  // pick on that view is then mapped back to a channel number.
  assign start_idx = (last_reg == SEL_W'(NUM_CH - 1)) ? '0 : last_reg + 1'b1;
  assign req_dbl   = {req, req};
  assign req_rot   = NUM_CH'(req_dbl >> start_idx);
  assign pick_sum  = {1'b0, start_idx} + {1'b0, pick_off};
  assign pick_id   = (pick_sum >= (SEL_W+1)'(NUM_CH)) ?
                     SEL_W'(pick_sum - (SEL_W+1)'(NUM_CH)) : pick_sum[SEL_W-1:0];

  // Lowest set bit of the rotated requests is the winner's offset.
  always_comb begin
    pick_off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = SEL_W'(k);
    end
  end

  // Address multiplexers for the arbitration winner and the current owner.
  always_comb begin
    pick_addr = '0;
    own_addr  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pick_id == SEL_W'(k))    pick_addr = addr_arr[k];
      if (gnt_id_reg == SEL_W'(k)) own_addr  = addr_arr[k];
    end
  end

  // gnt_reg is one-hot on the owner while granted, so it masks req directly.
  assign owner_req  = |(req & gnt_reg);
  assign others_req = |(req & ~gnt_reg);
  assign rotate_due = (MAX_HOLD != 0) && (hold_reg == CNT_W'(MAX_HOLD - 1)) && others_req;

  // Next-state and next-output logic; default is to hold everything.
  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    gnt_id_next = gnt_id_reg;
    valid_next  = valid_reg;
    rs_out_next = rs_out_reg;
    hold_next   = hold_reg;
    last_next   = last_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next  = GRANT;
          gnt_next    = NUM_CH'(1) << pick_id;
          gnt_id_next = pick_id;
          valid_next  = 1'b1;
          rs_out_next = pick_addr;
          hold_next   = '0;
          last_next   = pick_id;
        end
      end
      GRANT: begin
        if (!owner_req || rotate_due) begin
          // Release and forced rotation look the same: drop to IDLE, keep rs_out.
          state_next = IDLE;
          gnt_next   = '0;
          valid_next = 1'b0;
        end else begin
          rs_out_next = own_addr;
          if (hold_reg < CNT_W'(MAX_HOLD)) hold_next = hold_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset favours channel 0 on the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      gnt_id_reg <= '0;
      valid_reg  <= 1'b0;
      rs_out_reg <= '0;
      hold_reg   <= '0;
      last_reg   <= SEL_W'(NUM_CH - 1);
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      gnt_id_reg <= gnt_id_next;
      valid_reg  <= valid_next;
      rs_out_reg <= rs_out_next;
      hold_reg   <= hold_next;
      last_reg   <= last_next;
    end
  end

  assign gnt      = gnt_reg;
  assign gnt_id   = gnt_id_reg;
  assign rs_valid = valid_reg;
  assign rs_out   = rs_out_reg;

endmodule

// File: tb/tb_rs_port_arbiter.sv
// Directed testbench for rs_port_arbiter (NUM_CH=3, ADDR_WIDTH=5, MAX_HOLD=4).
// A vector table covers arbitration order, release and forced rotation;
// hand-written sequences cover the sole requester and asynchronous reset.

module tb_rs_port_arbiter;

  localparam int NUM_CH = 3;
  localparam int AW     = 5;
  localparam int NV     = 18;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH*AW-1:0] rs_in;
  logic [NUM_CH-1:0]    gnt;
  logic [1:0]           gnt_id;
  logic                 rs_valid;
  logic [AW-1:0]        rs_out;

  int checks   = 0;
  int failures = 0;

  rs_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rs_in(rs_in),
    .gnt(gnt), .gnt_id(gnt_id), .rs_valid(rs_valid), .rs_out(rs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] req;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [2:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic [4:0] rs;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] eg, input logic [1:0] eid,
                           input logic ev, input logic [4:0] ers);
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_valid"}, 32'(rs_valid), 32'(ev));
    check({tag, "_rs_out"}, 32'(rs_out), 32'(ers));
    if (ev) check({tag, "_gnt_id"}, 32'(gnt_id), 32'(eid));
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [2:0] r, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [4:0] a2);
    @(negedge clk);
    req   = r;
    rs_in = {a2, a1, a0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Simultaneous requests after reset: ch0, ch1, ch2 each for 2 cycles.
    vecs[0]  = '{3'b111, 5'd7,  5'd12, 5'd20, 3'b001, 2'd0, 1'b1, 5'd7};
    vecs[1]  = '{3'b111, 5'd8,  5'd12, 5'd20, 3'b001, 2'd0, 1'b1, 5'd8};
    vecs[2]  = '{3'b110, 5'd8,  5'd12, 5'd20, 3'b000, 2'd0, 1'b0, 5'd8};
    vecs[3]  = '{3'b110, 5'd8,  5'd12, 5'd20, 3'b010, 2'd1, 1'b1, 5'd12};
    vecs[4]  = '{3'b110, 5'd8,  5'd12, 5'd20, 3'b010, 2'd1, 1'b1, 5'd12};
    vecs[5]  = '{3'b100, 5'd8,  5'd12, 5'd20, 3'b000, 2'd0, 1'b0, 5'd12};
    vecs[6]  = '{3'b100, 5'd8,  5'd12, 5'd20, 3'b100, 2'd2, 1'b1, 5'd20};
    vecs[7]  = '{3'b100, 5'd8,  5'd12, 5'd21, 3'b100, 2'd2, 1'b1, 5'd21};
    vecs[8]  = '{3'b000, 5'd8,  5'd12, 5'd21, 3'b000, 2'd0, 1'b0, 5'd21};
    // Single request on ch0, then release holds rs_out.
    vecs[9]  = '{3'b001, 5'd7,  5'd12, 5'd20, 3'b001, 2'd0, 1'b1, 5'd7};
    vecs[10] = '{3'b000, 5'd30, 5'd12, 5'd20, 3'b000, 2'd0, 1'b0, 5'd7};
    // Forced rotation: ch1 holds, ch2 joins; 4 grant cycles, 1 bubble, then ch2.
    vecs[11] = '{3'b010, 5'd7,  5'd12, 5'd20, 3'b010, 2'd1, 1'b1, 5'd12};
    vecs[12] = '{3'b110, 5'd7,  5'd13, 5'd20, 3'b010, 2'd1, 1'b1, 5'd13};
    vecs[13] = '{3'b110, 5'd7,  5'd14, 5'd20, 3'b010, 2'd1, 1'b1, 5'd14};
    vecs[14] = '{3'b110, 5'd7,  5'd15, 5'd20, 3'b010, 2'd1, 1'b1, 5'd15};
    vecs[15] = '{3'b110, 5'd7,  5'd16, 5'd20, 3'b000, 2'd0, 1'b0, 5'd15};
    vecs[16] = '{3'b110, 5'd7,  5'd16, 5'd20, 3'b100, 2'd2, 1'b1, 5'd20};
    vecs[17] = '{3'b000, 5'd7,  5'd16, 5'd20, 3'b000, 2'd0, 1'b0, 5'd20};

    rst_n = 1'b0;
    req   = '0;
    rs_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'b000, 2'd0, 1'b0, 5'd0);
    check("reset_gnt_id", 32'(gnt_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].a2);
      $display("vec%0d req=%b gnt=%b id=%0d valid=%b rs_out=%0d", i, vecs[i].req,
               gnt, gnt_id, rs_valid, rs_out);
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].rs);
    end

    // Sole requester: ch0 alone for 20 cycles; rs_in 3 then 9 passes through.
    for (int c = 0; c < 20; c++) begin
      logic [4:0] a;
      a = (c < 10) ? 5'd3 : 5'd9;
      step(3'b001, a, 5'd12, 5'd20);
      $display("sole c=%0d gnt=%b rs_out=%0d", c, gnt, rs_out);
      check_all($sformatf("sole%0d", c), 3'b001, 2'd0, 1'b1, a);
    end
    step(3'b000, 5'd1, 5'd12, 5'd20);
    $display("sole_release gnt=%b valid=%b rs_out=%0d", gnt, rs_valid, rs_out);
    check_all("sole_release", 3'b000, 2'd0, 1'b0, 5'd9);

    // Reset mid-grant: ch1 granted (last owner was ch0), then async reset.
    step(3'b010, 5'd7, 5'd12, 5'd20);
    check_all("pre_reset", 3'b010, 2'd1, 1'b1, 5'd12);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async_reset gnt=%b id=%0d valid=%b rs_out=%0d", gnt, gnt_id, rs_valid, rs_out);
    check_all("async_reset", 3'b000, 2'd0, 1'b0, 5'd0);
    check("async_reset_gnt_id", 32'(gnt_id), 32'd0);
    @(posedge clk);
    #1;
    check_all("reset_held", 3'b000, 2'd0, 1'b0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b010, 5'd7, 5'd12, 5'd20);
    $display("after_reset gnt=%b id=%0d valid=%b rs_out=%0d", gnt, gnt_id, rs_valid, rs_out);
    check_all("after_reset", 3'b010, 2'd1, 1'b1, 5'd12);

    // Fresh arbitration after reset favours ch0 over ch1.
    step(3'b000, 5'd7, 5'd12, 5'd20);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(3'b011, 5'd4, 5'd12, 5'd20);
    $display("rr_after_reset gnt=%b id=%0d rs_out=%0d", gnt, gnt_id, rs_out);
    check_all("rr_after_reset", 3'b001, 2'd0, 1'b1, 5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_port_arbiter.md
RS_PORT_ARBITER -- requirements
Module: rs_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 3, number of requesting controllers (2..8).
- ADDR_WIDTH, `ADDR_WIDTH, register-address width.
- MAX_HOLD, 8, maximum grant cycles before forced rotation; 0 disables rotation.
- SEL_W, $clog2(NUM_CH), derived; not overridden.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- req, in, NUM_CH, per-channel request; held high for as long as the channel wants the port.
- rs_in, in, NUM_CH*ADDR_WIDTH, packed source addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt, out, NUM_CH, one-hot grant, registered.
- gnt_id, out, SEL_W, binary index of the owner, registered.
- rs_valid, out, 1, high while rs_out belongs to a granted owner.
- rs_out, out, ADDR_WIDTH, registered selected address.

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-004 IDLE: if any req bit is high at an edge, the block SHALL enter GRANT at that edge with the following outputs.
- owner = first requesting index searched round-robin from (last_owner+1) mod NUM_CH.
- gnt = one-hot(owner); gnt_id = owner; rs_valid = 1.
- rs_out = rs_in slice of owner, sampled at that edge.
REQ-005 Grant latency from the first req edge in IDLE SHALL be exactly 1 cycle.
REQ-006 GRANT with req[owner]=1 and no rotation due: at each edge rs_out SHALL load the owner's rs_in slice, giving 1-cycle pass-through latency.
REQ-007 GRANT with req[owner]=0 at an edge: the block SHALL return to IDLE, clear gnt and rs_valid, and hold rs_out at its last value.
REQ-008 hold_cnt SHALL reset to 0 on entry to GRANT and increment each cycle in GRANT, saturating at MAX_HOLD.
REQ-009 If MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and any other req bit is high, the next edge SHALL force a transition to IDLE, identical to a release.
REQ-010 Re-arbitration SHALL always cost exactly one IDLE bubble cycle; there SHALL be no direct owner-to-owner handoff.
REQ-011 last_owner SHALL update on every GRANT entry and SHALL NOT change in IDLE.
REQ-012 gnt SHALL always be one-hot or zero, with gnt != 0 iff state == GRANT iff rs_valid == 1.
REQ-013 If the owner is the sole requester, the grant SHALL persist indefinitely regardless of MAX_HOLD.
REQ-014 Changes to req of non-owners during GRANT SHALL NOT affect rs_out or gnt, except through the rotation rule.
REQ-015 req and rs_in SHALL be sampled only at clock edges; no output SHALL depend combinationally on any input.

Reset
REQ-016 rst_n low SHALL immediately force the following, regardless of clk: state = IDLE, gnt = 0, gnt_id = 0, rs_valid = 0, rs_out = 0, hold_cnt = 0, last_owner = NUM_CH-1 (so the first arbitration favours channel 0).
REQ-017 Reset asserted mid-grant SHALL abort the grant with no residual state; the first edge after rst_n rises SHALL arbitrate afresh.

Verification (NUM_CH=3, ADDR_WIDTH=5, MAX_HOLD=4)
REQ-018 The bench SHALL cover these directed scenarios:
- Single request: req=001, rs_in ch0=5'd7, from IDLE -> one edge later gnt=001, gnt_id=0, rs_valid=1, rs_out=7.
- Simultaneous requests: req=111 after reset -> grants in order ch0, ch1, ch2, each dropping req after 2 cycles, with one IDLE bubble between owners.
- Forced rotation: ch1 holds req while ch2 requests -> ch1 grant lasts exactly 4 cycles, then 1 IDLE cycle, then gnt=100.
- Sole requester: ch0 holds req alone for 20 cycles -> gnt stays 001 throughout; pass-through of rs_in changes 3->9 appears on rs_out one cycle later.
- Release: owner drops req -> next edge gnt=000, rs_valid=0, rs_out holds its last value.
- Reset mid-grant: rst_n low between edges -> all outputs 0 immediately; with req=010 after release, gnt=010 one edge later.
